// File: rtl/soc_wb2sram_bridge.sv
// Wishbone B3 slave to single-port SRAM bridge: classic cycles and incrementing bursts (linear, wrap-4/8/16).
// Optional address bounds check is compiled in with `define WB2SRAM_BOUNDS_CHECK_EN.
//
//   state  | meaning
//   IDLE   | waiting for a request; a read is issued in the request cycle
//   ACTIVE | acking beats; writes land at adr_q, burst reads prefetch the next word
//   ERR    | out-of-range access, error response for one cycle
module soc_wb2sram_bridge #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int WORD_AW       = AW - ((DW / 8) >> 1),
  parameter int MEM_SIZE_BYTE = 'h8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      wb_adr_i,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic [DW/8-1:0]    wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [DW/8-1:0]    sram_sel,
  input  logic [DW-1:0]      sram_dout
);

  localparam int SW    = DW / 8;
  localparam int SHIFT = SW >> 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERR    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WORD_AW-1:0] adr_q, adr_d;
  logic [WORD_AW-1:0] adr_inc, adr_next, adr_in;
  logic [AW-1:0]      adr_shifted;
  logic               req, burst;
  logic               oob_in, oob_next;
  logic               err_raw;

  assign req         = wb_cyc_i & wb_stb_i;
  assign burst       = req & (wb_cti_i == 3'b010);
  assign adr_shifted = wb_adr_i >> SHIFT;
  assign adr_in      = adr_shifted[WORD_AW-1:0];
  assign adr_inc     = adr_q + WORD_AW'(1);

  // Wrapping bursts only carry into the low bits; the upper word address stays put.
  always_comb begin
    adr_next = adr_inc;
    case (wb_bte_i)
      2'b01:   adr_next = {adr_q[WORD_AW-1:2], adr_inc[1:0]};
      2'b10:   adr_next = {adr_q[WORD_AW-1:3], adr_inc[2:0]};
      2'b11:   adr_next = {adr_q[WORD_AW-1:4], adr_inc[3:0]};
      default: adr_next = adr_inc;
    endcase
  end

`ifdef WB2SRAM_BOUNDS_CHECK_EN
  localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_SIZE_BYTE);

  assign oob_in   = {1'b0, wb_adr_i} >= MEM_LIMIT;
  assign oob_next = (((AW+1)'(adr_next)) << SHIFT) >= MEM_LIMIT;
  assign wb_err_o = err_raw;
`else
  assign oob_in   = 1'b0;
  assign oob_next = 1'b0;
  assign wb_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_waddr = adr_q;
    wb_ack_o   = 1'b0;
    err_raw    = 1'b0;
    case (state_q)
      IDLE: begin
        sram_waddr = adr_in;
        if (req) begin
          adr_d = adr_in;
          if (oob_in) begin
            state_d = ERR;
          end else begin
            state_d = ACTIVE;
            if (!wb_we_i) begin
              sram_ce = 1'b1;
              sram_oe = 1'b1;
            end
          end
        end
      end
      ACTIVE: begin
        wb_ack_o = req;
        if (req && wb_we_i) begin
          sram_ce = 1'b1;
          sram_we = 1'b1;
        end
        if (burst) begin
          adr_d = adr_next;
          if (oob_next) begin
            state_d = ERR;
          end else if (!wb_we_i) begin
            // Prefetch the next beat so reads keep one beat per cycle.
            sram_ce    = 1'b1;
            sram_oe    = 1'b1;
            sram_waddr = adr_next;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        err_raw = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      sram_ce  = 1'b0;
      sram_we  = 1'b0;
      sram_oe  = 1'b0;
      wb_ack_o = 1'b0;
      err_raw  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
    end
  end

  assign wb_dat_o = sram_dout;
  assign sram_din = wb_dat_i;
  assign sram_sel = wb_sel_i;
  assign wb_rty_o = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{1'b0, adr_shifted, err_raw, (MEM_SIZE_BYTE != 0)};

endmodule

// File: tb/tb_soc_wb2sram_bridge.sv
// Self-checking bench for soc_wb2sram_bridge: vector table, hand-written corner sequences and
// randomized traffic checked against a word-array reference memory.
module tb_soc_wb2sram_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WB2SRAM_BOUNDS_CHECK_EN
  localparam int MEM_BYTES = 'h1000;
`else
  localparam int MEM_BYTES = 'h8000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic        sram_ce, sram_we, sram_oe;
  logic [29:0] sram_waddr;
  logic [31:0] sram_din;
  logic [3:0]  sram_sel;
  logic [31:0] sram_dout;

  always #5 clk = ~clk;

  soc_wb2sram_bridge #(.AW(AW), .DW(DW), .MEM_SIZE_BYTE(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe), .sram_waddr(sram_waddr),
    .sram_din(sram_din), .sram_sel(sram_sel), .sram_dout(sram_dout)
  );

  // SRAM macro stand-in: 256 words, addresses alias on the low 8 bits.
  logic [31:0] sram_mem [256];
  logic        mem_clr = 1'b1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
      sram_dout <= '0;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_sel[b]) sram_mem[sram_waddr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
      end else if (sram_oe) begin
        sram_dout <= sram_mem[sram_waddr[7:0]];
      end
    end
  end

  logic [31:0] ref_mem [256];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] want;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] rd;
  logic [31:0] wrap_want[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic void ref_wr(input logic [29:0] w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[w[7:0]][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic drive(input logic cs, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    @(negedge clk);
    wb_cyc_i = cs; wb_stb_i = cs; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = bte;
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    chk({tag, "_idle_ack"}, wb_ack_o, 1'b0);
    chk({tag, "_idle_ce"}, sram_ce, 1'b0);
  endtask

  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata);
    drive(1'b1, we, adr, dat, sel, 3'b000, 2'b00);
    chk("cl_req_ack", wb_ack_o, 1'b0);
    chk("cl_req_ctl", {sram_ce, sram_we, sram_oe}, we ? 3'b000 : 3'b101);
    if (!we) chk("cl_req_waddr", sram_waddr, adr >> 2);
    drive(1'b1, we, adr, dat, sel, 3'b000, 2'b00);
    chk("cl_ack", wb_ack_o, 1'b1);
    chk("cl_err", wb_err_o, 1'b0);
    chk("cl_ack_ctl", {sram_ce, sram_we, sram_oe}, we ? 3'b110 : 3'b000);
    if (we) begin
      chk("cl_wr_waddr", sram_waddr, adr >> 2);
      ref_wr(30'(adr >> 2), dat, sel);
    end
    rdata = wb_dat_o;
    idle_cycle("cl");
  endtask

  // Beat addresses come straight from the burst rules: linear counts up, wrap-L stays in an aligned L-word block.
  task automatic burst(input logic we, input logic [31:0] start, input logic [1:0] bte, input int n,
                       input bit fixed);
    int          len;
    int          sw;
    int          a[16];
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  cti;
    len = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : (bte == 2'b11) ? 16 : 0;
    sw  = int'(start >> 2);
    for (int k = 0; k < n; k++)
      a[k] = (len == 0) ? sw + k : ((sw & ~(len - 1)) | ((sw + k) % len));
    cti = (n == 1) ? 3'b111 : 3'b010;
    drive(1'b1, we, start, 32'h0, 4'hF, cti, bte);
    chk("bst_req_ack", wb_ack_o, 1'b0);
    chk("bst_req_ctl", {sram_ce, sram_we, sram_oe}, we ? 3'b000 : 3'b101);
    if (!we) chk("bst_req_waddr", sram_waddr, a[0]);
    for (int k = 0; k < n; k++) begin
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      d   = fixed ? 32'(k + 1) : $urandom;
      s   = fixed ? 4'hF : 4'($urandom_range(1, 15));
      drive(1'b1, we, 32'(a[k]) << 2, d, s, cti, bte);
      chk("bst_ack", wb_ack_o, 1'b1);
      if (we) begin
        chk("bst_wr_ctl", {sram_ce, sram_we, sram_oe}, 3'b110);
        chk("bst_wr_waddr", sram_waddr, a[k]);
        ref_wr(30'(a[k]), d, s);
      end else begin
        chk("bst_rd_data", wb_dat_o, ref_mem[a[k] % 256]);
        if (k < n - 1) begin
          chk("bst_rd_ctl", {sram_ce, sram_we, sram_oe}, 3'b101);
          chk("bst_rd_waddr", sram_waddr, a[k + 1]);
        end else begin
          chk("bst_last_ctl", {sram_ce, sram_we, sram_oe}, 3'b000);
        end
      end
    end
    idle_cycle("bst");
  endtask

  task automatic back_to_back();
    drive(1'b1, 1'b1, 32'h30, 32'hCAFE0001, 4'hF, 3'b000, 2'b00);
    chk("b2b_w_req_ack", wb_ack_o, 1'b0);
    drive(1'b1, 1'b1, 32'h30, 32'hCAFE0001, 4'hF, 3'b000, 2'b00);
    chk("b2b_w_ack", wb_ack_o, 1'b1);
    ref_wr(30'd12, 32'hCAFE0001, 4'hF);
    drive(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("b2b_r_req_ack", wb_ack_o, 1'b0);
    chk("b2b_r_issue", {sram_ce, sram_we, sram_oe}, 3'b101);
    drive(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("b2b_r_ack", wb_ack_o, 1'b1);
    chk("b2b_r_data", wb_dat_o, 32'hCAFE0001);
    idle_cycle("b2b");
  endtask

  task automatic drop_mid_burst();
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("drop_beat0_ack", wb_ack_o, 1'b1);
    chk("drop_beat0_data", wb_dat_o, ref_mem[16]);
    drive(1'b0, 1'b0, 32'h44, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("drop_ack", wb_ack_o, 1'b0);
    chk("drop_ce", sram_ce, 1'b0);
    idle_cycle("drop");
  endtask

  task automatic rst_mid_burst();
    drive(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("rstb_beat0_ack", wb_ack_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    wb_adr_i = 32'h84;
    #1;
    chk("rstb_ack", wb_ack_o, 1'b0);
    chk("rstb_ctl", {sram_ce, sram_we, sram_oe}, 3'b000);
    chk("rstb_err", wb_err_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    chk("rstb_after_ack", wb_ack_o, 1'b0);
    chk("rstb_after_ce", sram_ce, 1'b0);
    idle_cycle("rstb");
  endtask

`ifdef WB2SRAM_BOUNDS_CHECK_EN
  task automatic bounds_test();
    drive(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("oob_req_ctl", {sram_ce, sram_we, sram_oe}, 3'b000);
    chk("oob_req_ack", wb_ack_o, 1'b0);
    drive(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("oob_err", wb_err_o, 1'b1);
    chk("oob_ack", wb_ack_o, 1'b0);
    chk("oob_ce", sram_ce, 1'b0);
    idle_cycle("oob");
    drive(1'b1, 1'b0, 32'hFF8, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("oobb_issue_waddr", sram_waddr, 30'h3FE);
    drive(1'b1, 1'b0, 32'hFF8, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("oobb_ack0", wb_ack_o, 1'b1);
    chk("oobb_pref_waddr", sram_waddr, 30'h3FF);
    drive(1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("oobb_ack1", wb_ack_o, 1'b1);
    chk("oobb_no_pref", sram_ce, 1'b0);
    drive(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b010, 2'b00);
    chk("oobb_err", wb_err_o, 1'b1);
    chk("oobb_noack", wb_ack_o, 1'b0);
    idle_cycle("oobb");
  endtask
`endif

  task automatic random_test(input int iters);
    logic [31:0] a;
    logic [31:0] r;
    for (int t = 0; t < iters; t++) begin
      a = (32'($urandom_range(0, 200)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          classic(1'b1, a, $urandom, 4'($urandom_range(1, 15)), r);
        end else begin
          classic(1'b0, a, 32'h0, 4'hF, r);
          chk("rnd_rd", r, ref_mem[a[9:2]]);
        end
      end else begin
        burst(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom_range(1, 8), 1'b0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        4'b1111, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0};
    vecs[3] = '{1'b1, 32'h21, 32'h0000AA00, 4'b0010, 32'h0};
    vecs[4] = '{1'b0, 32'h20, 32'h0,        4'b1111, 32'h1122AA44};
    vecs[5] = '{1'b1, 32'h22, 32'h77880000, 4'b1100, 32'h0};
    vecs[6] = '{1'b0, 32'h23, 32'h0,        4'b1111, 32'h7788AA44};
    wrap_want[0] = 32'd2; wrap_want[1] = 32'd3; wrap_want[2] = 32'd4; wrap_want[3] = 32'd1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
    chk("rst_rd_ctl", {sram_ce, sram_we, sram_oe}, 3'b000);
    chk("rst_ack", wb_ack_o, 1'b0);
    chk("rst_err", wb_err_o, 1'b0);
    chk("rst_rty", wb_rty_o, 1'b0);
    drive(1'b1, 1'b1, 32'h10, 32'h5, 4'hF, 3'b000, 2'b00);
    chk("rst_wr_ctl", {sram_ce, sram_we, sram_oe}, 3'b000);
    chk("rst_wr_ack", wb_ack_o, 1'b0);
    mem_clr = 1'b0;
    rst = 1'b0;
    idle_cycle("post_rst");

    for (int i = 0; i < 7; i++) begin
      classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
      if (!vecs[i].we) chk("tbl_rd", rd, vecs[i].want);
    end

    burst(1'b1, 32'h0C, 2'b01, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      classic(1'b0, 32'(i) << 2, 32'h0, 4'hF, rd);
      chk("wrap4_word", rd, wrap_want[i]);
    end
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd);
    chk("wrap4_no_spill", rd, 32'hDEADBEEF);

    burst(1'b0, 32'h100, 2'b00, 4, 1'b0);
    burst(1'b1, 32'h204, 2'b10, 8, 1'b0);
    burst(1'b0, 32'h21C, 2'b10, 8, 1'b0);
    burst(1'b1, 32'h2F0, 2'b11, 6, 1'b0);

    back_to_back();
    drop_mid_burst();
    rst_mid_burst();
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd);
    chk("post_rstb_rd", rd, 32'hDEADBEEF);

`ifdef WB2SRAM_BOUNDS_CHECK_EN
    bounds_test();
`endif

    random_test(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
